// File: rtl/mul_ctrl.sv
// RV32M multiply front-end: decodes MUL/MULH/MULHSU/MULHU, feeds magnitudes to an unsigned
// multiplier and restores the sign. Optional macro MUL_SWAP_EN puts the smaller magnitude on mul_a.
module mul_ctrl #(
  parameter int WAIT_LIMIT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_valid,
  input  logic [63:0] mul_res,
  input  logic        mul_ready
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DONE} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic          neg;
  logic [63:0]   prod;
  logic [CW-1:0] cnt;

  logic        sgn1, sgn2, neg_in;
  logic [31:0] abs1, abs2, a_sel, b_sel;
  logic [63:0] prod_fix;
  logic        wd_hit;

  // MUL is decoded as unsigned: its low word does not depend on signedness.
  assign sgn1   = (op == 2'b01) || (op == 2'b10);
  assign sgn2   = (op == 2'b01);
  assign neg_in = (sgn1 & rs1[31]) ^ (sgn2 & rs2[31]);
  assign abs1   = (sgn1 && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign abs2   = (sgn2 && rs2[31]) ? (~rs2 + 32'd1) : rs2;

`ifdef MUL_SWAP_EN
  // The shift-add multiplier iterates over mul_a, so give it the smaller magnitude.
  always_comb begin
    if (abs1 > abs2) begin
      a_sel = abs2;
      b_sel = abs1;
    end else begin
      a_sel = abs1;
      b_sel = abs2;
    end
  end
`else
  assign a_sel = abs1;
  assign b_sel = abs2;
`endif

  assign prod_fix = neg ? (~prod + 64'd1) : prod;
  assign wd_hit   = (WAIT_LIMIT != 0) && (cnt == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      neg       <= 1'b0;
      prod      <= 64'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= 32'd0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      mul_valid <= 1'b0;
    end else begin
      mul_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            neg       <= neg_in;
            mul_a     <= a_sel;
            mul_b     <= b_sel;
            mul_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A product arriving on the watchdog's last cycle still counts.
          if (mul_ready) begin
            prod  <= mul_res;
            state <= FIX;
          end else if (wd_hit) begin
            prod   <= 64'd0;
            result <= 32'd0;
            done   <= 1'b1;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          prod   <= prod_fix;
          result <= (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: ideal multiplier model with configurable latency and a
// result scoreboard filled at issue time and drained on done.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done, err;
  logic [31:0] result, mul_a, mul_b;
  logic        mul_valid;
  logic [63:0] mul_res;
  logic        mul_ready;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int          model_n   = 3;
  bit          model_en  = 1'b1;
  bit          inject    = 1'b0;
  int          valid_cnt = 0;
  int          m_cnt     = 0;
  logic [63:0] m_prod    = 64'd0;

  always #5 clk = ~clk;

  mul_ctrl #(.WAIT_LIMIT(40)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .err(err), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_res(mul_res), .mul_ready(mul_ready)
  );

  // Ideal multiplier: product on mul_ready, sampled model_n edges after the mul_valid edge.
  initial begin
    mul_ready = 1'b0;
    mul_res   = 64'd0;
    forever begin
      @(negedge clk);
      mul_ready = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          mul_ready = 1'b1;
          mul_res   = m_prod;
        end
      end
      if (inject) begin
        inject    = 1'b0;
        mul_ready = 1'b1;
        mul_res   = 64'h1234_5678_9ABC_DEF0;
      end
      if (mul_valid) begin
        valid_cnt = valid_cnt + 1;
        if (model_en) begin
          m_prod = {32'd0, mul_a} * {32'd0, mul_b};
          m_cnt  = model_n;
        end
      end
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
    return (s && x[31]) ? (32'd0 - x) : x;
  endfunction

  // n=0: multiplier never answers. Expected latency counts edges from the accepting edge
  // to the first edge at which done is sampled high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat, input bit hold);
    logic [31:0] xa, xb, tmp;
    exp_t e, got_e;
    int c;
    bit got;
    xa = mag(o == 2'b01 || o == 2'b10, a);
    xb = mag(o == 2'b01, b);
`ifdef MUL_SWAP_EN
    if (xa > xb) begin
      tmp = xa; xa = xb; xb = tmp;
    end
`else
    tmp = 32'd0;
`endif
    e.res = exp_res;
    e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    model_n = n; model_en = (n > 0); op = o; rs1 = a; rs2 = b; start = 1'b1; valid_cnt = 0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    c = 1; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    got_e = exp_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL done_timeout op=%0d: no done within 200 cycles", o);
    end else begin
      n_cmp += 5;
      if (c !== exp_lat) begin n_bad++; $display("FAIL latency: got %0d expected %0d", c, exp_lat); end
      if (result !== got_e.res) begin n_bad++; $display("FAIL result: got %h expected %h", result, got_e.res); end
      if (err !== got_e.err) begin n_bad++; $display("FAIL err: got %b expected %b", err, got_e.err); end
      if (mul_a !== xa) begin n_bad++; $display("FAIL mul_a: got %h expected %h", mul_a, xa); end
      if (mul_b !== xb) begin n_bad++; $display("FAIL mul_b: got %h expected %h", mul_b, xb); end
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp += 2;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b expected 0", done); end
    if (valid_cnt !== 1) begin n_bad++; $display("FAIL valid_count: got %0d expected 1", valid_cnt); end
    $display("op=%0d rs1=%h rs2=%h lat=%0d result=%h err=%b", o, a, b, c, result, err);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if ({busy, done, err, mul_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, mul_valid});
    end
    if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
    if ({mul_a, mul_b} !== 64'd0) begin n_bad++; $display("FAIL reset_operands: got %h expected 0", {mul_a, mul_b}); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6, 3, 32'h0000_002A, 1'b0, 6, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000, 1'b0, 5, 1'b0);
  endtask

  task automatic test_mulh();
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 3, 32'hFFFF_FFFF, 1'b0, 6, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 1'b0, 4, 1'b0);
  endtask

  task automatic test_mulhsu();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'h8000_0000, 1'b0, 7, 1'b0);
  endtask

  task automatic test_mulhu();
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 1'b0, 6, 1'b0);
    run_op(2'b11, 32'h0000_FFFF, 32'd3, 1, 32'd0, 1'b0, 4, 1'b0);
  endtask

  task automatic test_watchdog();
    run_op(2'b01, 32'd9, 32'd9, 0, 32'd0, 1'b1, 42, 1'b1);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 40, 32'hFFFF_FFFF, 1'b0, 43, 1'b0);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    @(negedge clk);
    model_en = 1'b0; op = 2'b00; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_wait: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_reset: got %b expected 0", busy); end
    if (result !== 32'd0) begin n_bad++; $display("FAIL result_after_reset: got %h expected 0", result); end
    inject = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin n_bad++; $display("FAIL late_ready: got %0d done pulses expected 0", done_seen); end
    $display("reset abort: busy=%b done_pulses=%0d", busy, done_seen);
    run_op(2'b00, 32'd3, 32'd5, 2, 32'd15, 1'b0, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a, b;
    int n;
    for (int k = 0; k < 12; k++) begin
      o = 2'($urandom_range(3));
      a = $urandom;
      b = $urandom;
      if (k == 0) a = 32'd0;
      if (k == 1) b = 32'h8000_0000;
      n = $urandom_range(1, 6);
      run_op(o, a, b, n, ref_mul(o, a, b), 1'b0, n + 3, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_mulhsu();
    test_mulhu();
    test_watchdog();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
